// File: rtl/multi_cycle_ctr_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// The master side is the controller; the slave side is the datapath.
interface multi_cycle_ctr_if #(
  parameter int OP_W = 6,
  parameter int ST_W = 4
);
  logic [OP_W-1:0] opcode;
  logic            memReady;
  logic            pcWrite;
  logic            pcWriteCond;
  logic            iorD;
  logic            memRead;
  logic            memWrite;
  logic            memToReg;
  logic            irWrite;
  logic            aluSrcA;
  logic            regWrite;
  logic            regDst;
  logic [1:0]      pcSource;
  logic [1:0]      aluSrcB;
  logic [1:0]      aluOp;
  logic            instrDone;
  logic            illegalOp;
  logic [ST_W-1:0] state;

  modport master (
    input  opcode, memReady,
    output pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg, irWrite,
           aluSrcA, regWrite, regDst, pcSource, aluSrcB, aluOp,
           instrDone, illegalOp, state
  );

  modport slave (
    output opcode, memReady,
    input  pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg, irWrite,
           aluSrcA, regWrite, regDst, pcSource, aluSrcB, aluOp,
           instrDone, illegalOp, state
  );
endinterface

// File: rtl/multi_cycle_ctr.sv
// Main control FSM of the multi-cycle MIPS datapath: sequences each instruction
// through fetch/decode/execute/memory/writeback and drives every datapath control.
module multi_cycle_ctr #(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  multi_cycle_ctr_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } stateT;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);

  stateT curState;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curState <= FETCH;
    end else begin
      case (curState)
        FETCH:  if (bus.memReady) curState <= DECODE;
        DECODE: begin
          case (bus.opcode)
            OP_LW, OP_SW: curState <= MEMADR;
            OP_RTYPE:     curState <= EXEC;
            OP_BEQ:       curState <= BRANCH;
            OP_J:         curState <= JUMP;
            OP_ADDI:      curState <= ADDIEX;
            default:      curState <= FETCH;
          endcase
        end
        MEMADR: curState <= (bus.opcode == OP_LW) ? MEMRD : MEMWR;
        MEMRD:  if (bus.memReady) curState <= MEMWB;
        MEMWR:  if (bus.memReady) curState <= FETCH;
        EXEC:   curState <= ALUWB;
        ADDIEX: curState <= ADDIWB;
        // Single-cycle tail states and the unused codes 12-15 all return to FETCH.
        default: curState <= FETCH;
      endcase
    end
  end

  // Outputs are gated by rst_n so they drop to 0 the moment reset asserts,
  // independent of the clock; FETCH and MEMWR also look at memReady.
  always_comb begin
    bus.pcWrite     = 1'b0;
    bus.pcWriteCond = 1'b0;
    bus.iorD        = 1'b0;
    bus.memRead     = 1'b0;
    bus.memWrite    = 1'b0;
    bus.memToReg    = 1'b0;
    bus.irWrite     = 1'b0;
    bus.aluSrcA     = 1'b0;
    bus.regWrite    = 1'b0;
    bus.regDst      = 1'b0;
    bus.pcSource    = 2'b00;
    bus.aluSrcB     = 2'b00;
    bus.aluOp       = 2'b00;
    bus.instrDone   = 1'b0;
    bus.illegalOp   = 1'b0;
    if (rst_n) begin
      case (curState)
        FETCH: begin
          bus.memRead = 1'b1;
          bus.aluSrcB = 2'b01;
          bus.irWrite = bus.memReady;
          bus.pcWrite = bus.memReady;
        end
        DECODE: begin
          bus.aluSrcB = 2'b11;
          case (bus.opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: ;
            default: begin
              bus.illegalOp = 1'b1;
              bus.instrDone = 1'b1;
            end
          endcase
        end
        MEMADR: begin
          bus.aluSrcA = 1'b1;
          bus.aluSrcB = 2'b10;
        end
        MEMRD: begin
          bus.memRead = 1'b1;
          bus.iorD    = 1'b1;
        end
        MEMWB: begin
          bus.regWrite  = 1'b1;
          bus.memToReg  = 1'b1;
          bus.instrDone = 1'b1;
        end
        MEMWR: begin
          bus.memWrite  = 1'b1;
          bus.iorD      = 1'b1;
          bus.instrDone = bus.memReady;
        end
        EXEC: begin
          bus.aluSrcA = 1'b1;
          bus.aluOp   = 2'b10;
        end
        ALUWB: begin
          bus.regDst    = 1'b1;
          bus.regWrite  = 1'b1;
          bus.instrDone = 1'b1;
        end
        BRANCH: begin
          bus.aluSrcA     = 1'b1;
          bus.aluOp       = 2'b01;
          bus.pcWriteCond = 1'b1;
          bus.pcSource    = 2'b01;
          bus.instrDone   = 1'b1;
        end
        JUMP: begin
          bus.pcWrite   = 1'b1;
          bus.pcSource  = 2'b10;
          bus.instrDone = 1'b1;
        end
        ADDIEX: begin
          bus.aluSrcA = 1'b1;
          bus.aluSrcB = 2'b10;
        end
        ADDIWB: begin
          bus.regWrite  = 1'b1;
          bus.instrDone = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.state = (rst_n) ? ST_W'(curState) : '0;

endmodule

// File: doc/multi_cycle_ctr.md
Name: multi_cycle_ctr

Overview:
- Main control FSM for the multi-cycle MIPS datapath; the producer of the 2-bit aluOp that the ALU control decoder consumes alongside funct.
- Sequences fetch/decode/execute/memory/writeback for R-type, lw, sw, beq, j and addi.
- Issues every datapath enable and mux select.
- Stalls on a memory ready handshake.

Parameters:
- OP_W, 6, opcode width.
- ST_W, 4, state register width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  6  instruction[31:26] from the instruction register; must be stable from DECODE until the instruction completes.
- memReady  input  1  memory completes the current access this cycle.
- pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg, irWrite, aluSrcA, regWrite, regDst  output  1 each  datapath controls.
- pcSource  output  2  00 ALU result, 01 ALUOut, 10 jump target.
- aluSrcB  output  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- aluOp  output  2  00 add, 01 subtract, 10 funct-decoded; 11 is never driven.
- instrDone  output  1  one-cycle pulse in the final cycle of each instruction.
- illegalOp  output  1  one-cycle pulse on an unsupported opcode.
- state  output  4  current state, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- Codes 12-15 are unreachable; if entered, next state is FETCH with all outputs 0.
- Reset: while rst_n=0, state=FETCH (0) and all control outputs, instrDone and illegalOp are 0. This holds asynchronously, including reset mid-instruction.
- After rst_n rises, the first clk edge evaluates FETCH normally.
- Outputs are Moore functions of state, except irWrite/pcWrite in FETCH and instrDone in MEMWR, which also qualify on memReady. Any output not listed for a state is 0.
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00, irWrite=pcWrite=memReady.
  - memReady=0: stay.
  - memReady=1: go to DECODE.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=00. Next state by opcode:
  - 100011 or 101011 -> MEMADR.
  - 000000 -> EXEC.
  - 000100 -> BRANCH.
  - 000010 -> JUMP.
  - 001000 -> ADDIEX.
  - other -> FETCH, with illegalOp=1 and instrDone=1 this cycle.
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. Opcode 100011 -> MEMRD, else MEMWR.
- MEMRD: memRead=1, iorD=1. Stay until memReady=1, then MEMWB.
- MEMWB: regWrite=1, memToReg=1, regDst=0, instrDone=1 -> FETCH.
- MEMWR: memWrite=1, iorD=1. Stay until memReady=1; that cycle instrDone=1 -> FETCH.
- EXEC: aluSrcA=1, aluSrcB=00, aluOp=10 -> ALUWB.
- ALUWB: regDst=1, regWrite=1, memToReg=0, instrDone=1 -> FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01, instrDone=1 -> FETCH.
- JUMP: pcWrite=1, pcSource=10, instrDone=1 -> FETCH.
- ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=00 -> ADDIWB.
- ADDIWB: regDst=0, regWrite=1, memToReg=0, instrDone=1 -> FETCH.
- Latency with memReady held at 1, FETCH to instrDone inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2 cycles. Each memory wait cycle adds 1.
- memWrite and regWrite are never both 1.
- irWrite is 1 only in FETCH.

Test Plan:
- Reset: rst_n=0 asserted mid-EXEC, asynchronously -> state=0 and all outputs 0 immediately, without waiting for clk; after release, FETCH with memRead=1.
- lw, opcode=100011, memReady=1 -> states 0,1,2,3,4; MEMWB shows regWrite=1, memToReg=1; instrDone pulses once on cycle 5.
- sw with memReady low 3 cycles in MEMWR -> memWrite=1 held 4 cycles; instrDone only on the memReady=1 cycle; regWrite never 1.
- R-type 000000 -> EXEC drives aluOp=10; ALUWB drives regDst=1, regWrite=1; beq 000100 -> BRANCH drives aluOp=01, pcWriteCond=1, pcSource=01.
- j 000010 -> JUMP drives pcWrite=1, pcSource=10; addi 001000 -> ADDIEX aluSrcB=10, aluOp=00, then ADDIWB regDst=0, regWrite=1.
- opcode=111111 -> DECODE pulses illegalOp=1 and instrDone=1, returns to FETCH; FETCH with memReady=0 -> irWrite=pcWrite=0 and state holds 0.
